// File: rtl/full_add_4.sv
// Registered ripple-carry adder slice: a + b + c_in captured one clock after
// in_valid, with carry-out, signed-overflow and zero flags and a valid strobe.
module full_add_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             carry_msb;

  // Ripple chain; carry walks the cells as a local variable, carry_msb keeps
  // the carry entering the top cell for the overflow flag.
  always_comb begin
    carry     = c_in;
    carry_msb = 1'b0;
    sum_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_next[i] = a[i] ^ b[i] ^ carry;
      if (i == WIDTH - 1) carry_msb = carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_next;
      c_out     <= carry;
      ovf       <= carry ^ carry_msb;
      zero      <= (sum_next == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_add_4.sv
// Self-checking bench for full_add_4: directed boundaries, hold behaviour,
// exhaustive sweep and random operands against an arithmetic reference.
module tb_full_add_4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] sum;
  logic       c_out;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  full_add_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input int av, input int bv, input int cv,
                       output logic [3:0] s, output logic co,
                       output logic ov, output logic z);
    int total, sa, sb, ss;
    total = av + bv + cv;
    s     = 4'(total % 16);
    co    = (total > 15);
    sa    = (av > 7) ? av - 16 : av;
    sb    = (bv > 7) ? bv - 16 : bv;
    ss    = sa + sb + cv;
    ov    = (ss > 7) || (ss < -8);
    z     = ((total % 16) == 0);
  endtask

  // Drive one operand set, capture on the next edge, compare everything.
  task automatic apply(input string tag, input int av, input int bv, input int cv);
    logic [3:0] es;
    logic       eco, eov, ez;
    a        = 4'(av);
    b        = 4'(bv);
    c_in     = cv[0];
    in_valid = 1'b1;
    model(av, bv, cv, es, eco, eov, ez);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"},   32'(sum),       32'(es));
    chk({tag, ".c_out"}, 32'(c_out),     32'(eco));
    chk({tag, ".ovf"},   32'(ovf),       32'(eov));
    chk({tag, ".zero"},  32'(zero),      32'(ez));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'd3;
    b        = 4'd4;
    c_in     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.sum",   32'(sum),       32'd0);
    chk("rst.c_out", 32'(c_out),     32'd0);
    chk("rst.ovf",   32'(ovf),       32'd0);
    chk("rst.zero",  32'(zero),      32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);

    rst_n = 1'b1;
    apply("post_rst", 3, 4, 0);

    apply("zero_in",  0, 0, 0);
    apply("d_3_4",    3, 4, 0);
    apply("d_2_5",    2, 5, 0);
    apply("ovf_9_9",  9, 9, 0);
    apply("c_10_15", 10, 15, 0);
    apply("wrap",    10, 5, 1);
    apply("max",     15, 15, 1);

    // Hold: in_valid low with random or unknown operands
    apply("hold_seed", 3, 4, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a    = 4'($urandom_range(15));
      b    = 4'($urandom_range(15));
      c_in = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      chk("hold.valid", 32'(out_valid), 32'd0);
      chk("hold.sum",   32'(sum),       32'd7);
      chk("hold.c_out", 32'(c_out),     32'd0);
      chk("hold.zero",  32'(zero),      32'd0);
    end
    a    = 'x;
    b    = 'x;
    c_in = 'x;
    @(posedge clk);
    #1;
    chk("hold_x.valid", 32'(out_valid), 32'd0);
    chk("hold_x.sum",   32'(sum),       32'd7);
    apply("pulse", 6, 1, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_end.valid", 32'(out_valid), 32'd0);
    chk("pulse_end.sum",   32'(sum),       32'd7);

    // Reset wins over a pending capture mid-stream
    apply("pre_mid_rst", 12, 7, 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'd5;
    b        = 4'd6;
    @(posedge clk);
    #1;
    chk("mid_rst.valid", 32'(out_valid), 32'd0);
    chk("mid_rst.sum",   32'(sum),       32'd0);
    chk("mid_rst.c_out", 32'(c_out),     32'd0);
    rst_n = 1'b1;

    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          apply("exh", ai, bi, ci);

    for (int i = 0; i < 100; i++)
      apply("rnd", int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(1)));

    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("final_idle.valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_add_4.md
Name: full_add_4

Overview:
- Registered 4-bit binary adder with carry-in and carry-out.
- Computes A + B + C_IN as a ripple chain of 1-bit full-adder cells and registers the result one clock later, with a valid strobe.
- Status flags: carry-out, signed overflow, zero.
- Used as the basic arithmetic leaf in datapath exercises; also a reusable small ALU adder slice.

Parameters:
- WIDTH, 4, operand/sum width in bits (all test values assume 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset (sampled on rising clk).
- in_valid  input  1  operands valid this cycle; result captured when high.
- a  input  WIDTH  operand A (unsigned; also read as two's complement for ovf).
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- sum  output  WIDTH  registered sum bits, (a+b+c_in) mod 2^WIDTH.
- c_out  output  1  registered carry-out of the MSB cell.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered, high when sum == 0 (independent of c_out).
- out_valid  output  1  high for one cycle per captured result.

Behaviour:
- One clock, single rising-edge domain; reset is synchronous and active-low. No asynchronous paths.
- Reset: on a rising edge with rst_n=0, sum=0, c_out=0, ovf=0, zero=0, out_valid=0. Reset has priority over in_valid. Reset asserted mid-stream drops any result pending in the same edge.
- Datapath structure:
  - WIDTH full-adder cells chained ripple-style; cell i: s_i = a_i ^ b_i ^ c_i, c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = c_in.
  - Combinational chain feeds the output registers directly; no input register.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - {c_out,sum} <= a+b+c_in (WIDTH+1-bit exact result).
  - ovf <= c_WIDTH ^ c_(WIDTH-1).
  - zero <= (sum_next == 0).
  - out_valid <= 1.
- Latency: exactly one cycle from in_valid high to out_valid high with matching result. Throughput: one result per cycle; back-to-back in_valid yields back-to-back out_valid.
- Idle: rising edge with rst_n=1 and in_valid=0 sets out_valid <= 0. sum, c_out, ovf and zero hold their last captured values.
- Boundaries:
  - Max inputs (a=b=all ones, c_in=1): sum=all ones, c_out=1.
  - Wrap to zero (e.g. 10+5+1): sum=0, c_out=1, zero=1.
  - All-zero inputs give zero=1, c_out=0.
- X on inputs with in_valid=0 must not disturb outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, a=3, b=4 -> all outputs 0, out_valid 0. Release; the next edge with a=3, b=4 -> sum=0111.
- Directed sums with c_in=0, one per cycle, in_valid=1, each result one cycle later with out_valid=1:
  - a=0, b=0 -> sum=0000, c_out=0, zero=1, ovf=0.
  - a=3, b=4 -> sum=0111, c_out=0, ovf=0.
  - a=2, b=5 -> sum=0111, c_out=0, ovf=0.
- Carry/overflow, c_in=0:
  - a=9, b=9 -> sum=0010, c_out=1, ovf=1.
  - a=10, b=15 -> sum=1001, c_out=1, ovf=0.
- Carry-in wrap: a=10, b=5, c_in=1 -> sum=0000, c_out=1, zero=1, ovf=0. a=15, b=15, c_in=1 -> sum=1111, c_out=1, ovf=0.
- Hold/valid: after a=3, b=4, drop in_valid and drive a/b with random values for 3 cycles -> out_valid=0, sum stays 0111. Then in_valid=1 for one cycle -> a single out_valid pulse.
- Exhaustive: all 512 (a, b, c_in) combinations back-to-back -> every cycle's {c_out,sum} equals the reference sum, and ovf/zero match their formulas.
